// File: rtl/uart_pkg.sv
// Shared definitions for the oversampling UART receiver: state encoding,
// majority vote, parity and baud-divider helpers.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    localparam int MAX_DATA_BITS = 9;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Rounded sysclk cycles per oversample tick.
    function automatic int calc_div(input longint clk_hz, input longint baud, input longint os);
        longint den;
        den = baud * os;
        return int'((clk_hz + den / 64'sd2) / den);
    endfunction

    // Zero padding of narrower words leaves the parity unchanged.
    function automatic logic parity_expect(input logic [MAX_DATA_BITS-1:0] data, input logic odd);
        return odd ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Oversample tick generator: sysclk divider plus per-bit sample counter,
// both restarted by align so the sample phase tracks the start edge.
module uart_os_tick #(
    parameter int DIV        = 651,
    parameter int OVERSAMPLE = 16
) (
    input  logic sysclk,
    input  logic reset,
    input  logic align,
    output logic tick,
    output logic mid_sample,
    output logic bit_done
);

    localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SAMP_W = $clog2(OVERSAMPLE);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(OVERSAMPLE - 1);
    localparam logic [SAMP_W-1:0] WIN_LO    = SAMP_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SAMP_W-1:0] WIN_HI    = SAMP_W'(OVERSAMPLE / 2 + 1);

    logic [DIV_W-1:0]  div_cnt_r;
    logic [SAMP_W-1:0] samp_cnt_r;
    logic              wrap_s;
    logic              in_window_s;

    assign wrap_s      = (div_cnt_r == DIV_LAST);
    assign in_window_s = (samp_cnt_r >= WIN_LO) && (samp_cnt_r <= WIN_HI);

    // Divider and sample counter with registered tick qualifiers.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            div_cnt_r  <= {DIV_W{1'b0}};
            samp_cnt_r <= {SAMP_W{1'b0}};
            tick       <= 1'b0;
            mid_sample <= 1'b0;
            bit_done   <= 1'b0;
        end else if (align) begin
            div_cnt_r  <= {DIV_W{1'b0}};
            samp_cnt_r <= {SAMP_W{1'b0}};
            tick       <= 1'b0;
            mid_sample <= 1'b0;
            bit_done   <= 1'b0;
        end else begin
            tick       <= wrap_s;
            mid_sample <= wrap_s && in_window_s;
            bit_done   <= wrap_s && (samp_cnt_r == WIN_HI);
            if (wrap_s) begin
                div_cnt_r  <= {DIV_W{1'b0}};
                samp_cnt_r <= (samp_cnt_r == SAMP_LAST) ? {SAMP_W{1'b0}} : samp_cnt_r + 1'b1;
            end else begin
                div_cnt_r  <= div_cnt_r + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx_os.sv
// Parametrised oversampling UART receiver with valid/ready output and error flags.
// Optional parity bit is compiled in with the UART_RX_PARITY_EN macro.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 100000000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic                 sysclk,
    input  logic                 reset,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 rx_busy
);

    localparam int         DIV       = calc_div(longint'(CLK_HZ), longint'(BAUD), longint'(OVERSAMPLE));
    localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic       STOP_LAST = (STOP_BITS == 2);

    if (DATA_BITS < 5 || DATA_BITS > MAX_DATA_BITS || STOP_BITS < 1 || STOP_BITS > 2 ||
        OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0 || PARITY_ODD < 0 || PARITY_ODD > 1 || DIV < 1) begin : g_bad_cfg
        $error("uart_rx_os: illegal parameter combination");
    end

    rx_state_t            state_r;
    logic                 sync1_r;
    logic                 rx_sync_r;
    logic                 rx_prev_r;
    logic [3:0]           bit_cnt_r;
    logic                 stop_cnt_r;
    logic [1:0]           samp_r;
    logic [DATA_BITS-1:0] data_sr_r;
    logic                 frame_err_r;
    logic                 commit_r;
    logic                 start_edge_s;
    logic                 maj_s;
    logic                 tick;
    logic                 mid_sample;
    logic                 bit_done;
`ifdef UART_RX_PARITY_EN
    logic                 parity_bad_r;
`endif

    assign start_edge_s = (state_r == ST_IDLE) && rx_prev_r && !rx_sync_r;
    assign maj_s        = maj3(samp_r[1], samp_r[0], rx_sync_r);

    uart_os_tick #(
        .DIV        (DIV),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_tick (
        .sysclk     (sysclk),
        .reset      (reset),
        .align      (start_edge_s),
        .tick       (tick),
        .mid_sample (mid_sample),
        .bit_done   (bit_done)
    );

    // Two-flop synchroniser plus one history flop for the falling-edge detect.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            sync1_r   <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            sync1_r   <= rxd;
            rx_sync_r <= sync1_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // Receive FSM: start qualification, data shift, optional parity, stop check.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            rx_busy     <= 1'b0;
            bit_cnt_r   <= 4'd0;
            stop_cnt_r  <= 1'b0;
            samp_r      <= 2'b00;
            data_sr_r   <= {DATA_BITS{1'b0}};
            frame_err_r <= 1'b0;
            commit_r    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bad_r <= 1'b0;
`endif
        end else begin
            commit_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start_edge_s) begin
                        state_r    <= ST_START;
                        rx_busy    <= 1'b1;
                        bit_cnt_r  <= 4'd0;
                        stop_cnt_r <= 1'b0;
                    end
                end
                default: begin
                    if (tick && mid_sample) begin
                        samp_r <= {samp_r[0], rx_sync_r};
                        if (bit_done) begin
                            case (state_r)
                                ST_START: begin
                                    if (maj_s) begin
                                        state_r <= ST_IDLE;
                                        rx_busy <= 1'b0;
                                    end else begin
                                        state_r     <= ST_DATA;
                                        frame_err_r <= 1'b0;
`ifdef UART_RX_PARITY_EN
                                        parity_bad_r <= 1'b0;
`endif
                                    end
                                end
                                ST_DATA: begin
                                    data_sr_r <= {maj_s, data_sr_r[DATA_BITS-1:1]};
                                    if (bit_cnt_r == DATA_LAST) begin
`ifdef UART_RX_PARITY_EN
                                        state_r <= ST_PARITY;
`else
                                        state_r <= ST_STOP;
`endif
                                    end else begin
                                        bit_cnt_r <= bit_cnt_r + 4'd1;
                                    end
                                end
`ifdef UART_RX_PARITY_EN
                                ST_PARITY: begin
                                    parity_bad_r <= maj_s != parity_expect(MAX_DATA_BITS'(data_sr_r), PARITY_ODD != 0);
                                    state_r      <= ST_STOP;
                                end
`endif
                                ST_STOP: begin
                                    frame_err_r <= frame_err_r | ~maj_s;
                                    // Leave at mid-stop so a following start edge is not missed.
                                    if (stop_cnt_r == STOP_LAST) begin
                                        commit_r <= 1'b1;
                                        state_r  <= ST_IDLE;
                                        rx_busy  <= 1'b0;
                                    end else begin
                                        stop_cnt_r <= stop_cnt_r + 1'b1;
                                    end
                                end
                                default: begin
                                    state_r <= ST_IDLE;
                                    rx_busy <= 1'b0;
                                end
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    // Output register: accept a committed word unless an unread word is still held.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            rx_data    <= {DATA_BITS{1'b0}};
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (commit_r && (!rx_valid || rx_ready)) begin
                rx_valid  <= 1'b1;
                rx_data   <= data_sr_r;
                frame_err <= frame_err_r;
`ifdef UART_RX_PARITY_EN
                parity_err <= parity_bad_r;
`else
                parity_err <= 1'b0;
`endif
            end else if (commit_r) begin
                overrun <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os: directed frames push expected words,
// a negedge monitor pops and compares on every accepted word.
module tb_uart_rx_os;

    localparam int CLK_HZ     = 100000000;
    localparam int BAUD       = 1000000;
    localparam int OVERSAMPLE = 16;
    localparam int BIT_CYC    = 96;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    typedef struct packed {
        logic [7:0] data;
        logic       fe;
        logic       pe;
    } exp_t;

    logic       sysclk   = 1'b0;
    logic       reset    = 1'b0;
    logic       rxd      = 1'b1;
    logic       rx_ready = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       parity_err;
    logic       overrun;
    logic       rx_busy;

    exp_t sb[$];
    int   checks    = 0;
    int   errors    = 0;
    int   cyc       = 0;
    int   ovr_cnt   = 0;
    int   acc_cyc   = 0;
    int   start_cyc = 0;
    logic flip_par  = 1'b0;

    uart_rx_os #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .DATA_BITS  (8),
        .STOP_BITS  (1),
        .OVERSAMPLE (OVERSAMPLE),
        .PARITY_ODD (1)
    ) dut (
        .sysclk     (sysclk),
        .reset      (reset),
        .rxd        (rxd),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun),
        .rx_busy    (rx_busy)
    );

    always #5 sysclk = ~sysclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rxd = b;
        step(BIT_CYC);
    endtask

    task automatic expect_word(input logic [7:0] d, input logic fe, input logic pe);
        sb.push_back('{data: d, fe: fe, pe: pe});
    endtask

    // Odd parity: the parity bit makes the total count of ones odd.
    task automatic send_frame(input logic [7:0] d, input logic stop_lvl, input int idle_bits);
        start_cyc = cyc;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(~(^d) ^ flip_par);
`endif
        send_bit(stop_lvl);
        rxd = 1'b1;
        step(idle_bits * BIT_CYC);
    endtask

    // Monitor: count overrun pulses, compare every accepted word against the scoreboard.
    initial forever begin
        @(negedge sysclk);
        cyc++;
        if (overrun) ovr_cnt++;
        if (rx_valid && rx_ready) begin
            check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("rx_data", 32'(rx_data), 32'(e.data));
                check("frame_err", 32'(frame_err), 32'(e.fe));
                check("parity_err", 32'(parity_err), 32'(e.pe));
                acc_cyc = cyc;
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        step(3);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_parity_err", 32'(parity_err), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_rx_busy", 32'(rx_busy), 32'd0);
        reset = 1'b1;
        step(5);

        // Nominal 0xE9 frame and its delivery latency.
        expect_word(8'hE9, 1'b0, 1'b0);
        send_frame(8'hE9, 1'b1, 2);
        check("e9_drained", 32'(sb.size()), 32'd0);
        lat = acc_cyc - start_cyc;
        check("e9_latency_window", 32'((lat >= (FRAME_BITS - 1) * BIT_CYC) && (lat <= FRAME_BITS * BIT_CYC)), 32'd1);

        // Reset during data bit 4 abandons the frame.
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(i[0]);
        step(BIT_CYC / 2);
        reset = 1'b0;
        step(2);
        check("midrst_rx_busy", 32'(rx_busy), 32'd0);
        check("midrst_rx_data", 32'(rx_data), 32'd0);
        check("midrst_rx_valid", 32'(rx_valid), 32'd0);
        reset = 1'b1;
        rxd   = 1'b1;
        step(2 * BIT_CYC);
        expect_word(8'h3C, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b1, 2);
        check("3c_drained", 32'(sb.size()), 32'd0);

        // Three back-to-back frames with the consumer stalled.
        rx_ready = 1'b0;
        ovr_cnt  = 0;
        expect_word(8'hE9, 1'b0, 1'b0);
        send_frame(8'hE9, 1'b1, 0);
        send_frame(8'hE9, 1'b1, 0);
        send_frame(8'hE9, 1'b1, 1);
        check("stall_rx_valid_held", 32'(rx_valid), 32'd1);
        check("stall_rx_data_held", 32'(rx_data), 32'hE9);
        check("stall_overrun_pulses", 32'(ovr_cnt), 32'd2);
        rx_ready = 1'b1;
        step(3);
        check("stall_rx_valid_fell", 32'(rx_valid), 32'd0);
        check("stall_drained", 32'(sb.size()), 32'd0);

        // Short low glitch is a false start.
        rxd = 1'b0;
        step(3);
        rxd = 1'b1;
        step(2);
        check("glitch_busy_high", 32'(rx_busy), 32'd1);
        step(BIT_CYC);
        check("glitch_busy_low", 32'(rx_busy), 32'd0);
        check("glitch_no_word", 32'(sb.size()), 32'd0);

        // Low stop bit, then a full-frame break.
        expect_word(8'h55, 1'b1, 1'b0);
        send_frame(8'h55, 1'b0, 2);
`ifdef UART_RX_PARITY_EN
        expect_word(8'h00, 1'b1, 1'b1);
`else
        expect_word(8'h00, 1'b1, 1'b0);
`endif
        rxd = 1'b0;
        step(FRAME_BITS * BIT_CYC);
        rxd = 1'b1;
        step(2 * BIT_CYC);
        check("break_drained", 32'(sb.size()), 32'd0);

`ifdef UART_RX_PARITY_EN
        flip_par = 1'b0;
        expect_word(8'hE9, 1'b0, 1'b0);
        send_frame(8'hE9, 1'b1, 2);
        flip_par = 1'b1;
        expect_word(8'hE9, 1'b0, 1'b1);
        send_frame(8'hE9, 1'b1, 2);
        flip_par = 1'b0;
        check("parity_drained", 32'(sb.size()), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
